// File: rtl/bnn_ctrl_pkg.sv
// Shared definitions for the binarized-layer controllers.
package bnn_ctrl_pkg;

  // Controller state encodings shared by all layer controllers.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input longint unsigned n);
    int unsigned     w;
    longint unsigned v;
    w = 0;
    v = (n > 64'd1) ? (n - 64'd1) : 64'd0;
    while (v > 64'd0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/fold_counter.sv
// Modulo-N counter with synchronous clear and enable; wrap_c flags value==N-1.
module fold_counter
  import bnn_ctrl_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = clog2(64'(N))
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] value,
  output logic         wrap_c
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  assign wrap_c = (value_q == W'(N - 1));
  assign value  = value_q;

  // Next count: clear wins over enable; wrap back to zero after N-1.
  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (en) begin
      value_d = wrap_c ? '0 : value_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/weight_fetch_scheduler.sv
// Walks images x neuron folds x synapse folds and streams weight addresses
// over a valid/ready handshake, flagging fold and image boundaries.
module weight_fetch_scheduler
  import bnn_ctrl_pkg::*;
#(
  parameter int unsigned SYNAPSE_FOLD = 18,
  parameter int unsigned NEURON_FOLD  = 4,
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned IMG_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IMG_WIDTH-1:0]  img_count,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  syn_last,
  output logic                  img_last
);

  localparam int unsigned TOTAL = SYNAPSE_FOLD * NEURON_FOLD;
  localparam int unsigned SYN_W = clog2(64'(SYNAPSE_FOLD));
  localparam int unsigned NRN_W = clog2(64'(NEURON_FOLD));
  localparam int unsigned ADR_W = clog2(64'(TOTAL));

  // Reject fold shapes that cannot be addressed.
  if (SYNAPSE_FOLD < 1 || NEURON_FOLD < 1 ||
      64'(TOTAL) > (64'd1 << ADDR_WIDTH)) begin : g_param_check
    $error("weight_fetch_scheduler: invalid fold / address width parameters");
  end

  logic [1:0]           state_q, state_d;
  logic [IMG_WIDTH-1:0] img_cnt_q, img_cnt_d;
  logic [IMG_WIDTH-1:0] img_max_q, img_max_d;
  logic                 run_q, run_d;
  logic                 done_q, done_d;

  logic                 cnt_clr_c;
  logic                 beat_c;
  logic                 syn_wrap_c;
  logic                 nrn_wrap_c;
  logic                 addr_wrap_c;
  logic [SYN_W-1:0]     syn_val;
  logic [NRN_W-1:0]     nrn_val;
  logic [ADR_W-1:0]     addr_val;
  logic                 unused_ok;

  // Synapse position inside the current neuron fold.
  fold_counter #(.N(SYNAPSE_FOLD), .W(SYN_W)) u_syn_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (beat_c),
    .value  (syn_val),
    .wrap_c (syn_wrap_c)
  );

  // Neuron fold inside the current image.
  fold_counter #(.N(NEURON_FOLD), .W(NRN_W)) u_nrn_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (beat_c && syn_wrap_c),
    .value  (nrn_val),
    .wrap_c (nrn_wrap_c)
  );

  // Running weight address; wraps together with the neuron fold counter.
  fold_counter #(.N(TOTAL), .W(ADR_W)) u_addr_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (cnt_clr_c),
    .en     (beat_c),
    .value  (addr_val),
    .wrap_c (addr_wrap_c)
  );

  assign unused_ok = ^{syn_val, nrn_val};

  // Next state, image bookkeeping and registered status outputs.
  always_comb begin
    state_d   = state_q;
    img_cnt_d = img_cnt_q;
    img_max_d = img_max_q;
    cnt_clr_c = 1'b0;
    beat_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_clr_c = 1'b1;
          img_cnt_d = '0;
          img_max_d = img_count - IMG_WIDTH'(1);
          state_d   = (img_count != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        beat_c = mem_ready;
        if (beat_c && addr_wrap_c) begin
          if (img_cnt_q == img_max_q) begin
            state_d = ST_DONE;
          end else begin
            img_cnt_d = img_cnt_q + IMG_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    run_d  = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      img_cnt_q <= '0;
      img_max_q <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      img_cnt_q <= img_cnt_d;
      img_max_q <= img_max_d;
      run_q     <= run_d;
      done_q    <= done_d;
    end
  end

  assign busy      = run_q;
  assign mem_valid = run_q;
  assign done      = done_q;
  assign mem_addr  = ADDR_WIDTH'(addr_val);
  assign syn_last  = run_q && syn_wrap_c;
  assign img_last  = run_q && syn_wrap_c && nrn_wrap_c;

endmodule

// File: tb/tb_weight_fetch_scheduler.sv
// Self-checking bench: small-fold instance (3x2) for directed cases and a
// default-parameter instance for a randomly stalled multi-image run.
module tb_weight_fetch_scheduler;

  localparam int unsigned AS = 3;
  localparam int unsigned AN = 2;
  localparam int unsigned BS = 18;
  localparam int unsigned BN = 4;

  typedef struct packed {
    logic [11:0] addr;
    logic        sl;
    logic        il;
  } beat_t;

  typedef struct {
    int unsigned img;
    int unsigned ready_mode;
    int unsigned exp_beats;
    int unsigned exp_syn;
    int unsigned exp_img;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_start, a_busy, a_done, a_valid, a_ready, a_syn_last, a_img_last;
  logic [15:0] a_img_count;
  logic [11:0] a_addr;
  logic        b_rst, b_start, b_busy, b_done, b_valid, b_ready, b_syn_last, b_img_last;
  logic [15:0] b_img_count;
  logic [11:0] b_addr;

  weight_fetch_scheduler #(.SYNAPSE_FOLD(AS), .NEURON_FOLD(AN), .ADDR_WIDTH(12), .IMG_WIDTH(16)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .img_count(a_img_count), .busy(a_busy), .done(a_done),
    .mem_addr(a_addr), .mem_valid(a_valid), .mem_ready(a_ready), .syn_last(a_syn_last), .img_last(a_img_last)
  );

  weight_fetch_scheduler dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .img_count(b_img_count), .busy(b_busy), .done(b_done),
    .mem_addr(b_addr), .mem_valid(b_valid), .mem_ready(b_ready), .syn_last(b_syn_last), .img_last(b_img_last)
  );

  beat_t sb_a[$];
  beat_t sb_b[$];
  beat_t ea, eb;
  int checks = 0;
  int errors = 0;
  int a_beats, a_syn, a_img, a_done_cnt;
  int b_beats, b_syn, b_img, b_done_cnt, b_max;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Expected beat stream for n images of syn x nrn folds.
  task automatic push_images(input int which, input int unsigned n, input int unsigned syn, input int unsigned nrn);
    beat_t e;
    for (int unsigned i = 0; i < n; i++)
      for (int unsigned k = 0; k < nrn; k++)
        for (int unsigned s = 0; s < syn; s++) begin
          e.addr = 12'(k * syn + s);
          e.sl   = (s == syn - 1);
          e.il   = (s == syn - 1) && (k == nrn - 1);
          if (which == 0) sb_a.push_back(e);
          else sb_b.push_back(e);
        end
  endtask

  // Beat monitor / scoreboard for the small instance.
  always @(negedge clk) begin
    if (!a_rst) begin
      if (a_valid && a_ready) begin
        a_beats++;
        if (a_syn_last) a_syn++;
        if (a_img_last) a_img++;
        if (sb_a.size() == 0) begin
          chk("a_unexpected_beat", 32'd1, 32'd0);
        end else begin
          ea = sb_a.pop_front();
          chk("a_addr", 32'(a_addr), 32'(ea.addr));
          chk("a_syn_last", 32'(a_syn_last), 32'(ea.sl));
          chk("a_img_last", 32'(a_img_last), 32'(ea.il));
        end
      end
      if (!a_valid && (a_syn_last || a_img_last)) chk("a_flags_without_valid", 32'(a_syn_last | a_img_last), 32'd0);
      if (a_done) a_done_cnt++;
    end
  end

  // Beat monitor / scoreboard for the default instance.
  always @(negedge clk) begin
    if (!b_rst) begin
      if (b_valid && b_ready) begin
        b_beats++;
        if (b_syn_last) b_syn++;
        if (b_img_last) b_img++;
        if (32'(b_addr) > b_max) b_max = 32'(b_addr);
        if (sb_b.size() == 0) begin
          chk("b_unexpected_beat", 32'd1, 32'd0);
        end else begin
          eb = sb_b.pop_front();
          chk("b_addr", 32'(b_addr), 32'(eb.addr));
          chk("b_syn_last", 32'(b_syn_last), 32'(eb.sl));
          chk("b_img_last", 32'(b_img_last), 32'(eb.il));
        end
      end
      if (b_done) b_done_cnt++;
    end
  end

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (!a_done && n < 1000) begin
      cycle();
      n++;
    end
    if (!a_done) begin
      chk({tag, "_done_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_busy_at_done"}, 32'(a_busy), 32'd0);
      chk({tag, "_valid_at_done"}, 32'(a_valid), 32'd0);
    end
    cycle();
    chk({tag, "_done_one_cycle"}, 32'(a_done), 32'd0);
  endtask

  // One start/complete transaction on the small instance from a table record.
  task automatic run_a(input vec_t v, input string tag);
    int lat;
    a_beats = 0; a_syn = 0; a_img = 0; a_done_cnt = 0;
    push_images(0, v.img, AS, AN);
    a_start = 1'b1;
    a_img_count = 16'(v.img);
    cycle();
    a_start = 1'b0;
    a_img_count = 16'hFFFF;
    if (v.img == 0) begin
      chk({tag, "_done_next"}, 32'(a_done), 32'd1);
      chk({tag, "_busy_zero"}, 32'(a_busy), 32'd0);
      chk({tag, "_valid_zero"}, 32'(a_valid), 32'd0);
      cycle();
      chk({tag, "_done_one_cycle"}, 32'(a_done), 32'd0);
    end else begin
      chk({tag, "_valid_first"}, 32'(a_valid), 32'd1);
      chk({tag, "_addr_first"}, 32'(a_addr), 32'd0);
      chk({tag, "_busy_first"}, 32'(a_busy), 32'd1);
      lat = 0;
      while (!a_done && lat < 1000) begin
        a_ready = (v.ready_mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
        cycle();
        lat++;
      end
      if (!a_done) begin
        chk({tag, "_done_timeout"}, 32'd0, 32'd1);
      end else begin
        chk({tag, "_busy_at_done"}, 32'(a_busy), 32'd0);
        chk({tag, "_valid_at_done"}, 32'(a_valid), 32'd0);
        if (v.ready_mode == 0) chk({tag, "_latency"}, 32'(lat), 32'(v.img * AS * AN));
      end
      a_ready = 1'b1;
      cycle();
      chk({tag, "_done_one_cycle"}, 32'(a_done), 32'd0);
    end
    chk({tag, "_beats"}, 32'(a_beats), 32'(v.exp_beats));
    chk({tag, "_syn_count"}, 32'(a_syn), 32'(v.exp_syn));
    chk({tag, "_img_count"}, 32'(a_img), 32'(v.exp_img));
    chk({tag, "_done_pulses"}, 32'(a_done_cnt), 32'd1);
    chk({tag, "_sb_empty"}, 32'(sb_a.size()), 32'd0);
  endtask

  initial begin
    int n;
    vecs[0] = '{img: 1, ready_mode: 0, exp_beats: 6,  exp_syn: 2, exp_img: 1};
    vecs[1] = '{img: 2, ready_mode: 0, exp_beats: 12, exp_syn: 4, exp_img: 2};
    vecs[2] = '{img: 3, ready_mode: 1, exp_beats: 18, exp_syn: 6, exp_img: 3};
    vecs[3] = '{img: 0, ready_mode: 0, exp_beats: 0,  exp_syn: 0, exp_img: 0};

    a_rst = 1'b1; a_start = 1'b0; a_img_count = '0; a_ready = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_img_count = '0; b_ready = 1'b0;
    a_beats = 0; a_syn = 0; a_img = 0; a_done_cnt = 0;
    b_beats = 0; b_syn = 0; b_img = 0; b_done_cnt = 0; b_max = 0;
    repeat (2) cycle();
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_flags", 32'({a_syn_last, a_img_last}), 32'd0);
    chk("rst_b_valid", 32'(b_valid), 32'd0);
    chk("rst_b_addr", 32'(b_addr), 32'd0);
    a_rst = 1'b0; b_rst = 1'b0;
    cycle();
    chk("idle_valid", 32'(a_valid), 32'd0);
    chk("idle_busy", 32'(a_busy), 32'd0);

    // Table-driven transactions.
    for (int i = 0; i < 4; i++) begin
      run_a(vecs[i], $sformatf("vec%0d", i));
      cycle();
    end

    // Backpressure held at address 1.
    push_images(0, 1, AS, AN);
    a_ready = 1'b1; a_start = 1'b1; a_img_count = 16'd1;
    cycle();
    a_start = 1'b0;
    cycle();
    chk("bp_addr_before", 32'(a_addr), 32'd1);
    a_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_addr_hold", 32'(a_addr), 32'd1);
      chk("bp_valid_hold", 32'(a_valid), 32'd1);
      chk("bp_flags_hold", 32'({a_syn_last, a_img_last}), 32'd0);
    end
    a_ready = 1'b1;
    wait_done_a("bp");
    chk("bp_sb_empty", 32'(sb_a.size()), 32'd0);

    // Zero images; start in the done cycle is ignored, one cycle later accepted.
    a_start = 1'b1; a_img_count = 16'd0;
    cycle();
    chk("z_done", 32'(a_done), 32'd1);
    chk("z_busy", 32'(a_busy), 32'd0);
    chk("z_valid", 32'(a_valid), 32'd0);
    a_img_count = 16'd1;
    cycle();
    chk("z_start_ignored_valid", 32'(a_valid), 32'd0);
    chk("z_done_cleared", 32'(a_done), 32'd0);
    push_images(0, 1, AS, AN);
    cycle();
    a_start = 1'b0;
    chk("z_restart_valid", 32'(a_valid), 32'd1);
    chk("z_restart_addr", 32'(a_addr), 32'd0);
    wait_done_a("z");
    chk("z_sb_empty", 32'(sb_a.size()), 32'd0);

    // Reset at address 4, with a competing start; then a clean restart.
    push_images(0, 1, AS, AN);
    a_ready = 1'b1; a_start = 1'b1; a_img_count = 16'd1;
    cycle();
    a_start = 1'b0;
    repeat (4) cycle();
    chk("r_addr_before", 32'(a_addr), 32'd4);
    a_rst = 1'b1; a_start = 1'b1;
    cycle();
    a_start = 1'b0; a_rst = 1'b0;
    chk("r_valid", 32'(a_valid), 32'd0);
    chk("r_addr", 32'(a_addr), 32'd0);
    chk("r_flags", 32'({a_syn_last, a_img_last}), 32'd0);
    chk("r_busy", 32'(a_busy), 32'd0);
    chk("r_done", 32'(a_done), 32'd0);
    sb_a.delete();
    cycle();
    run_a(vecs[0], "r_restart");

    // Default parameters: three images under random stalls.
    push_images(1, 3, BS, BN);
    b_start = 1'b1; b_img_count = 16'd3;
    cycle();
    b_start = 1'b0; b_img_count = 16'd7;
    chk("b_valid_first", 32'(b_valid), 32'd1);
    n = 0;
    while (!b_done && n < 5000) begin
      b_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n++;
    end
    if (!b_done) chk("b_done_timeout", 32'd0, 32'd1);
    else chk("b_busy_at_done", 32'(b_busy), 32'd0);
    repeat (3) cycle();
    chk("b_beats", 32'(b_beats), 32'd216);
    chk("b_syn_count", 32'(b_syn), 32'd12);
    chk("b_img_count", 32'(b_img), 32'd3);
    chk("b_max_addr", 32'(b_max), 32'd71);
    chk("b_done_pulses", 32'(b_done_cnt), 32'd1);
    chk("b_sb_empty", 32'(sb_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
